// File: rtl/dcache_pkg.sv
// Shared geometry, state encodings and address helper for the data-cache refill path.
// Fixed 4-way geometry: 32 KiB, 16-byte lines, 32-bit addresses and memory words.
package dcache_pkg;

    localparam int unsigned ASSOC       = 4;
    localparam int unsigned CACHE_SIZE  = 32768;
    localparam int unsigned BLOCK_SIZE  = 16;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned DATA_WIDTH  = 32;

    localparam int unsigned OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int unsigned INDEX_BITS  = $clog2(CACHE_SIZE / (BLOCK_SIZE * ASSOC));
    localparam int unsigned TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned WORDS       = BLOCK_SIZE / 4;
    localparam int unsigned WORD_BITS   = $clog2(WORDS);
    localparam int unsigned WAY_BITS    = 2;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [WORD_BITS-1:0]  word_t;
    typedef logic [WAY_BITS-1:0]   way_t;

    typedef enum logic [2:0] {
        IDLE, VICTIM, WB_RD, WB_REQ, WB_RSP, FILL_REQ, FILL_RSP, COMMIT
    } refill_state_e;

    typedef enum logic [1:0] {
        MEM_IDLE, MEM_REQ, MEM_RSP
    } mem_state_e;

    // Request payload handed to the memory transaction tracker
    typedef struct packed {
        logic  we;
        addr_t addr;
    } mem_req_t;

    // Word-aligned byte address of one word within a line
    function automatic addr_t line_addr(input tag_t tag, input idx_t idx, input word_t word);
        return {tag, idx, word, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_refill_ctrl_if.sv
// OBI-style data memory port of the refill engine.
// master: refill engine (drives req/we/addr/wdata); slave: memory (drives gnt/rvalid/rdata).
interface dcache_refill_ctrl_if;
    import dcache_pkg::*;

    logic  mem_req_o;
    logic  mem_we_o;
    addr_t mem_addr_o;
    data_t mem_wdata_o;
    logic  mem_gnt_i;
    logic  mem_rvalid_i;
    data_t mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/dcache_mem_if.sv
// Single-outstanding OBI transaction tracker shared by write-back and fill.
// Ports: clk/rst; issue_c + issue_req_c start a request; wb_data is the data-array
// read word (valid in the first request cycle); mem is the memory port;
// granted_c / rsp_c flag the grant and the matching response of the open request.
module dcache_mem_if
    import dcache_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     issue_c,
    input  mem_req_t issue_req_c,
    input  data_t    wb_data,
    dcache_refill_ctrl_if.master mem,
    output logic     granted_c,
    output logic     rsp_c
);

    mem_state_e state_q, state_n;
    logic       req_q, req_n;
    logic       we_q, we_n;
    addr_t      addr_q, addr_n;
    data_t      wdata_q, wdata_n;
    logic       fresh_q, fresh_n;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_n;
            req_q   <= req_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            fresh_q <= fresh_n;
        end
    end

    // Hold the request until granted; only rvalid after a grant counts as a response
    always_comb begin
        state_n   = state_q;
        req_n     = req_q;
        we_n      = we_q;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        fresh_n   = 1'b0;
        granted_c = 1'b0;
        rsp_c     = 1'b0;

        // Array read data is only present in the first request cycle; keep it for stalls
        if (state_q == MEM_REQ && fresh_q) begin
            wdata_n = wb_data;
        end

        case (state_q)
            MEM_REQ: begin
                if (mem.mem_gnt_i) begin
                    granted_c = 1'b1;
                    state_n   = MEM_RSP;
                    req_n     = 1'b0;
                    we_n      = 1'b0;
                    addr_n    = '0;
                end
            end
            MEM_RSP: begin
                if (mem.mem_rvalid_i) begin
                    rsp_c   = 1'b1;
                    state_n = MEM_IDLE;
                end
            end
            default: ;
        endcase

        if (issue_c) begin
            state_n = MEM_REQ;
            req_n   = 1'b1;
            we_n    = issue_req_c.we;
            addr_n  = issue_req_c.addr;
            fresh_n = 1'b1;
        end
    end

    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = (req_q && we_q) ? (fresh_q ? wb_data : wdata_q) : '0;

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: picks the LRU victim, writes it back if dirty,
// fetches the new line word 0..3, installs it and reports the filled way.
// Ports: miss/victim inputs from lookup and LRU tracker; busy/done/lru_* status;
// line_* data-array access; tag_* tag-array write; mem = OBI memory port.
module dcache_refill_ctrl
    import dcache_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  miss_i,
    input  addr_t miss_addr_i,
    input  way_t  lru_select_i,
    input  logic  victim_valid_i,
    input  logic  victim_dirty_i,
    input  tag_t  victim_tag_i,
    output logic  busy_o,
    output logic  done_o,
    output logic  lru_miss_o,
    output way_t  lru_way_o,
    output logic  line_rd_o,
    output logic  line_we_o,
    output way_t  line_way_o,
    output idx_t  line_idx_o,
    output word_t line_word_o,
    output data_t line_wdata_o,
    input  data_t line_rdata_i,
    output logic  tag_we_o,
    output tag_t  tag_o,
    dcache_refill_ctrl_if.master mem
);

    refill_state_e state_q, state_n;
    word_t    k_q, k_n;
    way_t     way_q, way_n;
    tag_t     vtag_q, vtag_n;
    tag_t     mtag_q, mtag_n;
    idx_t     idx_q, idx_n;
    logic     fill_we_c, issue_c, granted_c, rsp_c, rd_n, commit_n;
    mem_req_t issue_req_c;

    logic unused_offset;
    assign unused_offset = ^miss_addr_i[OFFSET_BITS-1:0];

    dcache_mem_if u_mem_if (
        .clk         (clk),
        .rst         (rst),
        .issue_c     (issue_c),
        .issue_req_c (issue_req_c),
        .wb_data     (line_rdata_i),
        .mem         (mem),
        .granted_c   (granted_c),
        .rsp_c       (rsp_c)
    );

    // State, captured context and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            way_q        <= '0;
            vtag_q       <= '0;
            mtag_q       <= '0;
            idx_q        <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            lru_miss_o   <= 1'b0;
            lru_way_o    <= '0;
            line_rd_o    <= 1'b0;
            line_we_o    <= 1'b0;
            line_way_o   <= '0;
            line_idx_o   <= '0;
            line_word_o  <= '0;
            line_wdata_o <= '0;
            tag_we_o     <= 1'b0;
            tag_o        <= '0;
        end else begin
            state_q      <= state_n;
            k_q          <= k_n;
            way_q        <= way_n;
            vtag_q       <= vtag_n;
            mtag_q       <= mtag_n;
            idx_q        <= idx_n;
            busy_o       <= (state_n != IDLE);
            done_o       <= commit_n;
            lru_miss_o   <= commit_n;
            lru_way_o    <= commit_n ? way_n : '0;
            line_rd_o    <= rd_n;
            line_we_o    <= fill_we_c;
            line_way_o   <= (rd_n || fill_we_c) ? way_n : '0;
            line_idx_o   <= (rd_n || fill_we_c) ? idx_n : '0;
            line_word_o  <= rd_n ? k_n : (fill_we_c ? k_q : '0);
            line_wdata_o <= fill_we_c ? mem.mem_rdata_i : '0;
            tag_we_o     <= commit_n;
            tag_o        <= commit_n ? mtag_n : '0;
        end
    end

    // Next-state and request issue
    always_comb begin
        state_n   = state_q;
        k_n       = k_q;
        way_n     = way_q;
        vtag_n    = vtag_q;
        mtag_n    = mtag_q;
        idx_n     = idx_q;
        fill_we_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_i) begin
                    mtag_n  = miss_addr_i[ADDR_WIDTH-1 -: TAG_BITS];
                    idx_n   = miss_addr_i[OFFSET_BITS +: INDEX_BITS];
                    state_n = VICTIM;
                end
            end
            // LRU tracker updates on negedge; its outputs are stable by now
            VICTIM: begin
                way_n   = lru_select_i;
                vtag_n  = victim_tag_i;
                k_n     = '0;
                state_n = (victim_valid_i && victim_dirty_i) ? WB_RD : FILL_REQ;
            end
            WB_RD:  state_n = WB_REQ;
            WB_REQ: if (granted_c) state_n = WB_RSP;
            WB_RSP: begin
                if (rsp_c) begin
                    if (k_q == word_t'(WORDS - 1)) begin
                        k_n     = '0;
                        state_n = FILL_REQ;
                    end else begin
                        k_n     = WORD_BITS'(k_q + 1'b1);
                        state_n = WB_RD;
                    end
                end
            end
            FILL_REQ: if (granted_c) state_n = FILL_RSP;
            FILL_RSP: begin
                if (rsp_c) begin
                    fill_we_c = 1'b1;
                    if (k_q == word_t'(WORDS - 1)) begin
                        k_n     = '0;
                        state_n = COMMIT;
                    end else begin
                        k_n     = WORD_BITS'(k_q + 1'b1);
                        state_n = FILL_REQ;
                    end
                end
            end
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        rd_n     = (state_n == WB_RD);
        commit_n = (state_n == COMMIT);

        // A new memory request starts on entry to a request state
        issue_c          = ((state_n == WB_REQ) || (state_n == FILL_REQ)) && (state_n != state_q);
        issue_req_c.we   = (state_n == WB_REQ);
        issue_req_c.addr = line_addr(issue_req_c.we ? vtag_n : mtag_n, idx_n, k_n);
    end

endmodule
